// File: rtl/obi_pkg.sv
// ----------------------------------------------------------------------------
// obi_pkg
//   Shared types and constants for the OBI memory responder.
//     OBI_DW           data width of the OBI bus (32)
//     obi_rsp_t        one response-pipeline stage: {valid, we, err, data}
//     obi_rsp_state_e  grant FSM states (IDLE, STALL)
//     OBI_RSP_EMPTY    an all-zero (invalid) response stage
// ----------------------------------------------------------------------------
package obi_pkg;

    localparam int unsigned OBI_DW = 32;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic              err;
        logic [OBI_DW-1:0] data;
    } obi_rsp_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } obi_rsp_state_e;

    localparam obi_rsp_t OBI_RSP_EMPTY = '0;

endpackage : obi_pkg

// File: rtl/obi_rsp_pipe.sv
// ----------------------------------------------------------------------------
// obi_rsp_pipe
//   Response pipeline of STAGES registered obi_rsp_t stages with async clear.
//   Stage 1 captures {valid, we, err} at the grant edge; the memory read data
//   only becomes valid one cycle later, so it is merged into stage 1 on the
//   way out (combinationally) rather than being registered there.
//
//   Ports:
//     clk      in   clock
//     rst_n    in   asynchronous active-low reset (flushes every stage)
//     rsp_i    in   command captured at grant (data field ignored)
//     rdata_i  in   raw memory read data, valid while stage 1 holds a read
//     rsp_o    out  last stage, data already merged and zeroed for writes
// ----------------------------------------------------------------------------
module obi_rsp_pipe
    import obi_pkg::*;
#(
    parameter int unsigned STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  obi_rsp_t          rsp_i,
    input  logic [OBI_DW-1:0] rdata_i,
    output obi_rsp_t          rsp_o
);

    obi_rsp_t stage_q [STAGES];
    obi_rsp_t stage1;

    // Stage 1 as seen by the rest of the pipe: read data from the memory,
    // zero for writes, errors and empty slots.
    always_comb begin
        stage1 = stage_q[0];
        if (stage_q[0].valid && !stage_q[0].we && !stage_q[0].err) begin
            stage1.data = rdata_i;
        end else begin
            stage1.data = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= OBI_RSP_EMPTY;
            end
        end else begin
            stage_q[0] <= rsp_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= (i == 1) ? stage1 : stage_q[i-1];
            end
        end
    end

    if (STAGES == 1) begin : g_single
        assign rsp_o = stage1;
    end else begin : g_multi
        assign rsp_o = stage_q[STAGES-1];
    end

endmodule : obi_rsp_pipe

// File: rtl/obi_mem_responder.sv
// ----------------------------------------------------------------------------
// obi_mem_responder
//   OBI slave-side front end for a simple synchronous memory. Grants requests
//   after GNT_WAIT wait states, forwards the granted access to the memory port
//   and returns the response exactly RESP_LAT cycles after the grant, in grant
//   order, with up to RESP_LAT transactions outstanding.
//
//   Parameters:
//     DEPTH     memory depth in 32-bit words
//     GNT_WAIT  wait cycles before gnt_o (0..15)
//     RESP_LAT  grant-to-rvalid latency (1..4)
//
//   Optional feature macro: OBI_MEM_RESPONDER_ERR_EN
//     defined   : out-of-range (addr_i[31:2] >= DEPTH) or be_i==0 accesses are
//                 granted without a memory strobe and answered with err_o=1
//     undefined : err_o tied 0, addresses wrap in the downstream memory
//
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     req_i/gnt_o                 OBI request / grant
//     addr_i, we_i, be_i, wdata_i OBI request payload
//     rvalid_o, rdata_o, err_o    OBI response
//     mem_req_o .. mem_wdata_o    memory strobe and payload (0 when idle)
//     mem_rdata_i                 memory read data, one cycle after mem_req_o
// ----------------------------------------------------------------------------
module obi_mem_responder
    import obi_pkg::*;
#(
    parameter int unsigned DEPTH    = 4096,
    parameter int unsigned GNT_WAIT = 0,
    parameter int unsigned RESP_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [OBI_DW-1:0] wdata_i,
    output logic              rvalid_o,
    output logic [OBI_DW-1:0] rdata_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_addr_o,
    output logic [OBI_DW-1:0] mem_wdata_o,
    input  logic [OBI_DW-1:0] mem_rdata_i
);

    localparam int unsigned WAIT = (GNT_WAIT > 15) ? 15 : GNT_WAIT;
    localparam int unsigned LAT  = (RESP_LAT < 1) ? 1 : ((RESP_LAT > 4) ? 4 : RESP_LAT);
    localparam logic [3:0]  WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    obi_rsp_state_e state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           gnt;
    logic           err_acc;
    logic           mem_req;
    obi_rsp_t       rsp_in;
    obi_rsp_t       rsp_out;

    // ------------------------------------------------------------------
    // Grant FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_i && (WAIT != 0)) begin
                    state_d = STALL;
                    cnt_d   = WAIT_INIT;
                end
            end
            STALL: begin
                if (!req_i) begin
                    // Request withdrawn mid-wait: abandon it without a grant.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        gnt = 1'b0;
        unique case (state_q)
            IDLE:    gnt = req_i && (WAIT == 0);
            STALL:   gnt = req_i && (cnt_q == '0);
            default: gnt = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Error decode
    // ------------------------------------------------------------------
`ifdef OBI_MEM_RESPONDER_ERR_EN
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    assign err_acc = (addr_i[31:2] >= DEPTH_W) || (be_i == '0);
`else
    assign err_acc = 1'b0;
`endif

    // The grant is combinational from req_i; gating it with rst_n keeps every
    // output at 0 while reset is held.
    assign gnt_o   = gnt && rst_n;
    assign mem_req = gnt_o && !err_acc;

    assign mem_req_o   = mem_req;
    assign mem_we_o    = mem_req ? we_i    : 1'b0;
    assign mem_be_o    = mem_req ? be_i    : '0;
    assign mem_addr_o  = mem_req ? addr_i  : '0;
    assign mem_wdata_o = mem_req ? wdata_i : '0;

    // ------------------------------------------------------------------
    // Response pipeline
    // ------------------------------------------------------------------
    always_comb begin
        rsp_in       = OBI_RSP_EMPTY;
        rsp_in.valid = gnt_o;
        rsp_in.we    = we_i;
        rsp_in.err   = err_acc;
    end

    obi_rsp_pipe #(
        .STAGES (LAT)
    ) u_rsp_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .rsp_i   (rsp_in),
        .rdata_i (mem_rdata_i),
        .rsp_o   (rsp_out)
    );

    assign rvalid_o = rsp_out.valid;
    assign rdata_o  = (rsp_out.valid && !rsp_out.we && !rsp_out.err) ? rsp_out.data : '0;

`ifdef OBI_MEM_RESPONDER_ERR_EN
    assign err_o = rsp_out.valid && rsp_out.err;
`else
    assign err_o = 1'b0;
`endif

endmodule : obi_mem_responder

// File: tb/tb_obi_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_obi_mem_responder
//   Four responder instances with different GNT_WAIT/RESP_LAT settings, each
//   backed by a behavioural memory. Expected responses go into a per-unit
//   queue when a request is driven and are popped when due.
//     unit 0: GNT_WAIT=0 RESP_LAT=1
//     unit 1: GNT_WAIT=3 RESP_LAT=2
//     unit 2: GNT_WAIT=2 RESP_LAT=1
//     unit 3: GNT_WAIT=0 RESP_LAT=3
// ----------------------------------------------------------------------------
module tb_obi_mem_responder;

    localparam int NU = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NU-1:0] req;
    logic [NU-1:0] we;
    logic [31:0]   addr  [NU];
    logic [31:0]   wdata [NU];
    logic [3:0]    be    [NU];

    wire [NU-1:0] gnt, rvalid, err, mem_req, mem_we;
    wire [31:0]   rdata     [NU];
    wire [31:0]   mem_addr  [NU];
    wire [31:0]   mem_wdata [NU];
    wire [31:0]   mem_rdata [NU];
    wire [3:0]    mem_be    [NU];

    logic [31:0] mem [NU][1024];

    for (genvar g = 0; g < NU; g++) begin : g_dut
        logic [31:0] rd_q;

        obi_mem_responder #(
            .DEPTH    (1024),
            .GNT_WAIT ((g == 1) ? 3 : ((g == 2) ? 2 : 0)),
            .RESP_LAT ((g == 1) ? 2 : ((g == 3) ? 3 : 1))
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .req_i       (req[g]),
            .gnt_o       (gnt[g]),
            .addr_i      (addr[g]),
            .we_i        (we[g]),
            .be_i        (be[g]),
            .wdata_i     (wdata[g]),
            .rvalid_o    (rvalid[g]),
            .rdata_o     (rdata[g]),
            .err_o       (err[g]),
            .mem_req_o   (mem_req[g]),
            .mem_we_o    (mem_we[g]),
            .mem_be_o    (mem_be[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_wdata_o (mem_wdata[g]),
            .mem_rdata_i (mem_rdata[g])
        );

        // Synchronous memory: read data valid the cycle after the strobe,
        // random garbage otherwise.
        always @(posedge clk) begin
            if (mem_req[g] && mem_we[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[g][b]) mem[g][mem_addr[g][11:2]][8*b +: 8] = mem_wdata[g][8*b +: 8];
                end
            end
            if (mem_req[g] && !mem_we[g]) rd_q <= mem[g][mem_addr[g][11:2]];
            else                          rd_q <= $urandom;
        end
        assign mem_rdata[g] = rd_q;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sbq [NU][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input int u, input int lat, input logic [31:0] d, input logic e);
        exp_t x;
        x.due  = cyc + lat;
        x.data = d;
        x.err  = e;
        sbq[u].push_back(x);
    endtask

    task automatic sb_check();
        exp_t x;
        for (int u = 0; u < NU; u++) begin
            if (sbq[u].size() != 0 && sbq[u][0].due == cyc) begin
                x = sbq[u].pop_front();
                chk($sformatf("u%0d_rvalid_c%0d", u, cyc), 32'(rvalid[u]), 32'd1);
                chk($sformatf("u%0d_rdata_c%0d", u, cyc), rdata[u], x.data);
                chk($sformatf("u%0d_err_c%0d", u, cyc), 32'(err[u]), 32'(x.err));
            end else begin
                chk($sformatf("u%0d_idle_rvalid_c%0d", u, cyc), 32'(rvalid[u]), 32'd0);
                chk($sformatf("u%0d_idle_rdata_c%0d", u, cyc), rdata[u], 32'd0);
            end
        end
    endtask

    task automatic mid();
        @(negedge clk);
        sb_check();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int u, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        req[u]   = r;
        we[u]    = w;
        addr[u]  = a;
        wdata[u] = d;
        be[u]    = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0;
        we  = '0;
        for (int u = 0; u < NU; u++) begin
            addr[u] = '0; wdata[u] = '0; be[u] = '0;
            for (int i = 0; i < 1024; i++) mem[u][i] = '0;
        end
        mem[0][4] = 32'hDEAD_BEEF;
        mem[0][0] = 32'h0BAD_F00D;
        mem[1][2] = 32'hCAFE_0002;

        // Reset: request held, nothing may come out
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        mid();
        chk("rst_gnt", 32'(gnt[0]), 32'd0);
        chk("rst_mem_req", 32'(mem_req[0]), 32'd0);
        chk("rst_mem_addr", mem_addr[0], 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nxt();
        rst_n = 1'b1;
        mid();
        nxt();

        // Unit 0: zero-wait read, response one cycle later
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        push(0, 1, 32'hDEAD_BEEF, 1'b0);
        mid();
        chk("t1_gnt", 32'(gnt[0]), 32'd1);
        chk("t1_mem_req", 32'(mem_req[0]), 32'd1);
        chk("t1_mem_addr", mem_addr[0], 32'h10);
        chk("t1_mem_we", 32'(mem_we[0]), 32'd0);
        chk("t1_mem_be", 32'(mem_be[0]), 32'hF);
        nxt();
        drive(0, 1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
        mid();
        chk("t1_idle_gnt", 32'(gnt[0]), 32'd0);
        chk("t1_idle_mem_req", 32'(mem_req[0]), 32'd0);
        chk("t1_idle_mem_addr", mem_addr[0], 32'd0);
        chk("t1_idle_mem_wdata", mem_wdata[0], 32'd0);
        chk("t1_idle_mem_we", 32'(mem_we[0]), 32'd0);
        nxt();

        // Unit 1: three wait states, grant in cycle 3, rvalid at 3+2
        drive(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        push(1, 5, 32'hCAFE_0002, 1'b0);
        for (int i = 0; i < 4; i++) begin
            mid();
            chk($sformatf("t2_gnt_c%0d", i), 32'(gnt[1]), 32'(i == 3));
            chk($sformatf("t2_mem_req_c%0d", i), 32'(mem_req[1]), 32'(i == 3));
            nxt();
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) begin mid(); nxt(); end

        // Unit 2: request dropped in STALL, then a full-wait write and readback
        drive(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        mid();
        chk("t3_gnt_first", 32'(gnt[2]), 32'd0);
        nxt();
        drive(2, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
        mid();
        chk("t3_gnt_drop", 32'(gnt[2]), 32'd0);
        chk("t3_mem_req_drop", 32'(mem_req[2]), 32'd0);
        nxt();
        mid();
        chk("t3_gnt_after_drop", 32'(gnt[2]), 32'd0);
        nxt();
        drive(2, 1'b1, 1'b1, 32'hC, 32'h5555_AAAA, 4'h3);
        push(2, 3, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            mid();
            chk($sformatf("t3_wait_gnt_c%0d", i), 32'(gnt[2]), 32'd0);
            chk($sformatf("t3_wait_mem_req_c%0d", i), 32'(mem_req[2]), 32'd0);
            nxt();
        end
        mid();
        chk("t3_gnt", 32'(gnt[2]), 32'd1);
        chk("t3_mem_we", 32'(mem_we[2]), 32'd1);
        chk("t3_mem_wdata", mem_wdata[2], 32'h5555_AAAA);
        chk("t3_mem_be", 32'(mem_be[2]), 32'h3);
        nxt();
        drive(2, 1'b1, 1'b0, 32'hC, 32'h0, 4'hF);
        push(2, 3, 32'h0000_AAAA, 1'b0);
        repeat (3) begin mid(); nxt(); end
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) begin mid(); nxt(); end

        // Unit 3: back-to-back write, write, read with RESP_LAT=3
        drive(3, 1'b1, 1'b1, 32'h0, 32'h1111_1111, 4'hF);
        push(3, 3, 32'h0, 1'b0);
        mid();
        chk("t4_gnt0", 32'(gnt[3]), 32'd1);
        nxt();
        drive(3, 1'b1, 1'b1, 32'h4, 32'h2222_2222, 4'hF);
        push(3, 3, 32'h0, 1'b0);
        mid();
        chk("t4_gnt1", 32'(gnt[3]), 32'd1);
        nxt();
        drive(3, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        push(3, 3, 32'h2222_2222, 1'b0);
        mid();
        chk("t4_gnt2", 32'(gnt[3]), 32'd1);
        chk("t4_mem_addr2", mem_addr[3], 32'h4);
        nxt();
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (4) begin mid(); nxt(); end

        // Unit 3: reset with two reads in flight; second must never appear
        drive(3, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        push(3, 3, 32'h1111_1111, 1'b0);
        mid();
        nxt();
        drive(3, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        mid();
        nxt();
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mid();
        nxt();
        mid();
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rvalid_async", 32'(rvalid[3]), 32'd0);
        chk("t5_rdata_async", rdata[3], 32'd0);
        nxt();
        mid();
        nxt();
        rst_n = 1'b1;
        repeat (5) begin mid(); nxt(); end

        // Unit 0: out-of-range address, then zero byte enables, back-to-back
        drive(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
`ifdef OBI_MEM_RESPONDER_ERR_EN
        push(0, 1, 32'h0, 1'b1);
        mid();
        chk("t6_gnt_oor", 32'(gnt[0]), 32'd1);
        chk("t6_mem_req_oor", 32'(mem_req[0]), 32'd0);
        nxt();
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        push(0, 1, 32'h0, 1'b1);
        mid();
        chk("t6_gnt_be0", 32'(gnt[0]), 32'd1);
        chk("t6_mem_req_be0", 32'(mem_req[0]), 32'd0);
        nxt();
`else
        push(0, 1, 32'h0BAD_F00D, 1'b0);
        mid();
        chk("t6_gnt_oor", 32'(gnt[0]), 32'd1);
        chk("t6_mem_req_oor", 32'(mem_req[0]), 32'd1);
        chk("t6_mem_addr_oor", mem_addr[0], 32'h0000_1000);
        nxt();
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        push(0, 1, 32'hDEAD_BEEF, 1'b0);
        mid();
        chk("t6_gnt_be0", 32'(gnt[0]), 32'd1);
        chk("t6_mem_req_be0", 32'(mem_req[0]), 32'd1);
        chk("t6_mem_be0", 32'(mem_be[0]), 32'd0);
        nxt();
`endif
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) begin mid(); nxt(); end

        for (int u = 0; u < NU; u++) begin
            chk($sformatf("u%0d_sb_empty", u), 32'(sbq[u].size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_obi_mem_responder
